controlador_multiciclo: RTL and testbench

Parametrised multicycle control unit for the datapath: a Moore FSM that sequences fetch, decode, register read, execute and write-back. It adds a configurable memory wait-state count, a start/done handshake with a variable-latency MULT/DIV unit, and a timeout. Illegal opcodes and multiply/divide timeouts are trapped into a sticky exception state. It drives the same datapath enables and mux selects as the previous controller.

---
 rtl/controlador_multiciclo_if.sv | 28 ++
 rtl/controlador_multiciclo.sv | 167 ++++++++++++++++
 tb/tb_controlador_multiciclo.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/controlador_multiciclo_if.sv
// Control/status bundle between the multicycle controller (master) and the datapath (slave).
interface controlador_multiciclo_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       md_done;
  logic       Load_PC, Load_IR, Load_A, Load_B, Load_ULAOut, RegWrite, Load_HI, Load_LO;
  logic       multStart, divStart;
  logic [1:0] ULAsrcA, ULAsrcB;
  logic [2:0] ULA_select;
  logic [1:0] WriteRegMux, WriteDataMux;
  logic [3:0] state;
  logic       exception;
  logic [1:0] cause;

  modport master (
    input  opcode, funct, md_done,
    output Load_PC, Load_IR, Load_A, Load_B, Load_ULAOut, RegWrite, Load_HI, Load_LO,
    output multStart, divStart, ULAsrcA, ULAsrcB, ULA_select, WriteRegMux, WriteDataMux,
    output state, exception, cause
  );

  modport slave (
    output opcode, funct, md_done,
    input  Load_PC, Load_IR, Load_A, Load_B, Load_ULAOut, RegWrite, Load_HI, Load_LO,
    input  multStart, divStart, ULAsrcA, ULAsrcB, ULA_select, WriteRegMux, WriteDataMux,
    input  state, exception, cause
  );
endinterface

// File: rtl/controlador_multiciclo.sv
// Multicycle Moore control unit with memory wait states, MULT/DIV handshake and a sticky trap state.
module controlador_multiciclo #(
  parameter int MEM_WAIT   = 0,
  parameter int MD_TIMEOUT = 64
) (
  input logic                      clk,
  input logic                      reset,
  controlador_multiciclo_if.master bus
);

  localparam logic [3:0] S_FETCH      = 4'd0;
  localparam logic [3:0] S_FETCH_WAIT = 4'd1;
  localparam logic [3:0] S_DECODE     = 4'd2;
  localparam logic [3:0] S_REGREAD    = 4'd3;
  localparam logic [3:0] S_EXEC       = 4'd4;
  localparam logic [3:0] S_MD_WAIT    = 4'd5;
  localparam logic [3:0] S_LOAD_HILO  = 4'd6;
  localparam logic [3:0] S_WRITEBACK  = 4'd7;
  localparam logic [3:0] S_EXCEPT     = 4'd8;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_ADDI = 3'd3;
  localparam logic [2:0] OP_MULT = 3'd4;
  localparam logic [2:0] OP_DIV  = 3'd5;
  localparam logic [2:0] OP_MFHI = 3'd6;
  localparam logic [2:0] OP_MFLO = 3'd7;

  localparam logic [3:0] WAIT_LAST = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;
  localparam logic [7:0] MD_LAST   = 8'(MD_TIMEOUT - 1);

  logic [3:0] r_state, w_nextState;
  logic [3:0] r_waitCnt;
  logic [7:0] r_mdCnt;
  logic [2:0] r_opClass, w_opClass;
  logic       w_legal;
  logic [1:0] r_cause;
  logic       w_mdTimeout;

  always_comb begin
    w_opClass = OP_ADD;
    w_legal   = 1'b0;
    if (bus.opcode == 6'h00) begin
      w_legal = 1'b1;
      case (bus.funct)
        6'h20:   w_opClass = OP_ADD;
        6'h22:   w_opClass = OP_SUB;
        6'h24:   w_opClass = OP_AND;
        6'h18:   w_opClass = OP_MULT;
        6'h1A:   w_opClass = OP_DIV;
        6'h10:   w_opClass = OP_MFHI;
        6'h12:   w_opClass = OP_MFLO;
        default: w_legal   = 1'b0;
      endcase
    end else if (bus.opcode == 6'h08) begin
      w_legal   = 1'b1;
      w_opClass = OP_ADDI;
    end
  end

  // md_done has priority over the timeout when both happen in the same cycle
  assign w_mdTimeout = !bus.md_done && (r_mdCnt == MD_LAST);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_FETCH:      w_nextState = (MEM_WAIT > 0) ? S_FETCH_WAIT : S_DECODE;
      S_FETCH_WAIT: if (r_waitCnt == WAIT_LAST) w_nextState = S_DECODE;
      S_DECODE:     w_nextState = S_REGREAD;
      S_REGREAD:    w_nextState = w_legal ? S_EXEC : S_EXCEPT;
      S_EXEC:       w_nextState = (r_opClass == OP_MULT || r_opClass == OP_DIV) ? S_MD_WAIT
                                                                                 : S_WRITEBACK;
      S_MD_WAIT: begin
        if (bus.md_done)  w_nextState = S_LOAD_HILO;
        else if (w_mdTimeout) w_nextState = S_EXCEPT;
      end
      S_LOAD_HILO:  w_nextState = S_FETCH;
      S_WRITEBACK:  w_nextState = S_FETCH;
      S_EXCEPT:     w_nextState = S_EXCEPT;
      default:      w_nextState = S_FETCH;
    endcase
  end

  // Counters sit at zero outside their state, so they are already cleared on entry
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_waitCnt <= 4'd0;
      r_mdCnt   <= 8'd0;
      r_opClass <= OP_ADD;
      r_cause   <= 2'b00;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= (r_state == S_FETCH_WAIT) ? r_waitCnt + 4'd1 : 4'd0;
      r_mdCnt   <= (r_state == S_MD_WAIT) ? r_mdCnt + 8'd1 : 8'd0;
      if (r_state == S_REGREAD) r_opClass <= w_opClass;
      if (r_state == S_REGREAD && !w_legal) r_cause <= 2'b01;
      else if (r_state == S_MD_WAIT && w_mdTimeout) r_cause <= 2'b10;
    end
  end

  // Outputs are forced low while reset is held, even before the register has been cleared
  always_comb begin
    bus.Load_PC      = 1'b0;
    bus.Load_IR      = 1'b0;
    bus.Load_A       = 1'b0;
    bus.Load_B       = 1'b0;
    bus.Load_ULAOut  = 1'b0;
    bus.RegWrite     = 1'b0;
    bus.Load_HI      = 1'b0;
    bus.Load_LO      = 1'b0;
    bus.multStart    = 1'b0;
    bus.divStart     = 1'b0;
    bus.ULAsrcA      = 2'b00;
    bus.ULAsrcB      = 2'b00;
    bus.ULA_select   = 3'b000;
    bus.WriteRegMux  = 2'b00;
    bus.WriteDataMux = 2'b00;
    bus.state        = 4'd0;
    bus.exception    = 1'b0;
    bus.cause        = 2'b00;
    if (!reset) begin
      bus.state = r_state;
      bus.cause = r_cause;
      case (r_state)
        S_FETCH: begin
          bus.Load_PC    = 1'b1;
          bus.ULAsrcB    = 2'b01;
          bus.ULA_select = 3'b001;
        end
        S_DECODE:  bus.Load_IR = 1'b1;
        S_REGREAD: begin
          bus.Load_A = 1'b1;
          bus.Load_B = 1'b1;
        end
        S_EXEC: begin
          case (r_opClass)
            OP_ADD, OP_SUB, OP_AND, OP_ADDI: begin
              bus.Load_ULAOut = 1'b1;
              bus.ULAsrcA     = 2'b01;
              bus.ULAsrcB     = (r_opClass == OP_ADDI) ? 2'b10 : 2'b00;
              bus.ULA_select  = (r_opClass == OP_SUB) ? 3'b010 :
                                (r_opClass == OP_AND) ? 3'b011 : 3'b001;
            end
            OP_MULT: bus.multStart = 1'b1;
            OP_DIV:  bus.divStart  = 1'b1;
            default: ;
          endcase
        end
        S_LOAD_HILO: begin
          bus.Load_HI = 1'b1;
          bus.Load_LO = 1'b1;
        end
        S_WRITEBACK: begin
          bus.RegWrite     = 1'b1;
          bus.WriteRegMux  = (r_opClass == OP_ADDI) ? 2'b01 : 2'b00;
          bus.WriteDataMux = (r_opClass == OP_MFHI) ? 2'b01 :
                             (r_opClass == OP_MFLO) ? 2'b10 : 2'b00;
        end
        S_EXCEPT: bus.exception = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_multiciclo.sv
// Randomized bench: two controller instances (different wait/timeout settings) checked per cycle
// against an instruction-level reference model that derives the expected state walk from latency rules.
module tb_controlador_multiciclo;

  typedef enum int {C_ADD, C_SUB, C_AND, C_ADDI, C_MULT, C_DIV, C_MFHI, C_MFLO, C_ILL} cls_t;

  typedef struct packed {
    logic       Load_PC, Load_IR, Load_A, Load_B, Load_ULAOut, RegWrite, Load_HI, Load_LO;
    logic       multStart, divStart;
    logic [1:0] ULAsrcA, ULAsrcB;
    logic [2:0] ULA_select;
    logic [1:0] WriteRegMux, WriteDataMux;
    logic [3:0] state;
    logic       exception;
    logic [1:0] cause;
  } outs_t;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mdDone;
  bit         sel;
  int         numCompared;
  int         numMismatched;

  controlador_multiciclo_if ifA ();
  controlador_multiciclo_if ifB ();

  assign ifA.opcode  = opcode;
  assign ifA.funct   = funct;
  assign ifA.md_done = mdDone;
  assign ifB.opcode  = opcode;
  assign ifB.funct   = funct;
  assign ifB.md_done = mdDone;

  controlador_multiciclo #(.MEM_WAIT(0), .MD_TIMEOUT(8)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (ifA)
  );

  controlador_multiciclo #(.MEM_WAIT(3), .MD_TIMEOUT(5)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (ifB)
  );

  outs_t obsA, obsB, obs;
  assign obsA = {ifA.Load_PC, ifA.Load_IR, ifA.Load_A, ifA.Load_B, ifA.Load_ULAOut, ifA.RegWrite,
                 ifA.Load_HI, ifA.Load_LO, ifA.multStart, ifA.divStart, ifA.ULAsrcA, ifA.ULAsrcB,
                 ifA.ULA_select, ifA.WriteRegMux, ifA.WriteDataMux, ifA.state, ifA.exception,
                 ifA.cause};
  assign obsB = {ifB.Load_PC, ifB.Load_IR, ifB.Load_A, ifB.Load_B, ifB.Load_ULAOut, ifB.RegWrite,
                 ifB.Load_HI, ifB.Load_LO, ifB.multStart, ifB.divStart, ifB.ULAsrcA, ifB.ULAsrcB,
                 ifB.ULA_select, ifB.WriteRegMux, ifB.WriteDataMux, ifB.state, ifB.exception,
                 ifB.cause};
  assign obs = sel ? obsB : obsA;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input outs_t got, input outs_t exp);
    numCompared++;
    if (got !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s (dut %0d): got %h expected %h", tag, sel, got, exp);
    end
  endtask

  function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h08) return C_ADDI;
    if (op != 6'h00) return C_ILL;
    case (fn)
      6'h20:   return C_ADD;
      6'h22:   return C_SUB;
      6'h24:   return C_AND;
      6'h18:   return C_MULT;
      6'h1A:   return C_DIV;
      6'h10:   return C_MFHI;
      6'h12:   return C_MFLO;
      default: return C_ILL;
    endcase
  endfunction

  task automatic pickEncoding(input cls_t c, output logic [5:0] op, output logic [5:0] fn);
    op = 6'h00;
    fn = 6'($urandom);
    case (c)
      C_ADD:   fn = 6'h20;
      C_SUB:   fn = 6'h22;
      C_AND:   fn = 6'h24;
      C_MULT:  fn = 6'h18;
      C_DIV:   fn = 6'h1A;
      C_MFHI:  fn = 6'h10;
      C_MFLO:  fn = 6'h12;
      C_ADDI:  op = 6'h08;
      default: begin
        do begin
          op = 6'($urandom);
          fn = 6'($urandom);
        end while (classify(op, fn) != C_ILL);
      end
    endcase
  endtask

  // Control word the datapath should see in a given state for a given instruction
  function automatic outs_t expOuts(input int st, input cls_t c, input int causeExp);
    outs_t o;
    o = '0;
    o.state = 4'(st);
    case (st)
      0: begin
        o.Load_PC = 1'b1; o.ULAsrcB = 2'b01; o.ULA_select = 3'b001;
      end
      2: o.Load_IR = 1'b1;
      3: begin
        o.Load_A = 1'b1; o.Load_B = 1'b1;
      end
      4: begin
        if (c == C_ADD || c == C_SUB || c == C_AND || c == C_ADDI) begin
          o.Load_ULAOut = 1'b1;
          o.ULAsrcA     = 2'b01;
          o.ULAsrcB     = (c == C_ADDI) ? 2'b10 : 2'b00;
          o.ULA_select  = (c == C_SUB) ? 3'b010 : (c == C_AND) ? 3'b011 : 3'b001;
        end
        o.multStart = (c == C_MULT);
        o.divStart  = (c == C_DIV);
      end
      6: begin
        o.Load_HI = 1'b1; o.Load_LO = 1'b1;
      end
      7: begin
        o.RegWrite     = 1'b1;
        o.WriteRegMux  = (c == C_ADDI) ? 2'b01 : 2'b00;
        o.WriteDataMux = (c == C_MFHI) ? 2'b01 : (c == C_MFLO) ? 2'b10 : 2'b00;
      end
      8: begin
        o.exception = 1'b1; o.cause = 2'(causeExp);
      end
      default: ;
    endcase
    return o;
  endfunction

  task automatic applyReset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      opcode = 6'($urandom);
      mdDone = 1'($urandom);
      #1;
      checkOutput("reset", obs, '0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  // Runs one instruction starting in its FETCH cycle; k = MD_WAIT cycle carrying md_done (0 = never),
  // abortAt = MD_WAIT cycle in which reset is raised (0 = none), hold = EXCEPT cycles to observe
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input int k,
                               input int abortAt, input int hold, output bit trapped);
    cls_t c;
    int   memWait, mdTimeout, causeExp, mdIdx;
    int   q[$];
    c         = classify(op, fn);
    memWait   = sel ? 3 : 0;
    mdTimeout = sel ? 5 : 8;
    causeExp  = 0;
    trapped   = 1'b0;
    q.push_back(0);
    repeat (memWait) q.push_back(1);
    q.push_back(2);
    q.push_back(3);
    if (c == C_ILL) begin
      causeExp = 1;
      repeat (hold) q.push_back(8);
    end else begin
      q.push_back(4);
      if (c == C_MULT || c == C_DIV) begin
        if (k >= 1 && k <= mdTimeout) begin
          repeat (k) q.push_back(5);
          q.push_back(6);
        end else begin
          causeExp = 2;
          repeat (mdTimeout) q.push_back(5);
          repeat (hold) q.push_back(8);
        end
      end else begin
        q.push_back(7);
      end
    end
    trapped = (causeExp != 0);
    mdIdx   = 0;
    foreach (q[i]) begin
      if (q[i] == 5) mdIdx++;
      if (q[i] == 3) begin
        opcode = op;
        funct  = fn;
      end else begin
        opcode = 6'($urandom);
        funct  = 6'($urandom);
      end
      mdDone = (q[i] == 5) ? (mdIdx == k) : 1'($urandom);
      if (q[i] == 5 && mdIdx == abortAt) begin
        reset  = 1'b1;
        mdDone = 1'b1;
        #1;
        checkOutput("resetInMd", obs, '0);
        @(posedge clk);
        #1;
        mdDone = 1'b0;
        #1;
        checkOutput("resetHeld", obs, '0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        trapped = 1'b0;
        return;
      end
      #1;
      checkOutput($sformatf("state%0d", q[i]), obs, expOuts(q[i], c, causeExp));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit         trapped;
    logic [5:0] op, fn;
    cls_t       c;
    numCompared   = 0;
    numMismatched = 0;
    sel    = 1'b0;
    reset  = 1'b1;
    opcode = 6'h00;
    funct  = 6'h00;
    mdDone = 1'b0;
    @(posedge clk);
    #1;
    applyReset(2);

    applyStimulus(6'h00, 6'h20, 0, 0, 0, trapped);
    applyStimulus(6'h00, 6'h24, 0, 0, 0, trapped);

    sel = 1'b1;
    applyReset(1);
    applyStimulus(6'h08, 6'h15, 0, 0, 0, trapped);

    sel = 1'b0;
    applyReset(1);
    applyStimulus(6'h00, 6'h1A, 4, 0, 0, trapped);
    applyStimulus(6'h00, 6'h12, 0, 0, 0, trapped);

    applyStimulus(6'h00, 6'h18, 0, 0, 20, trapped);
    applyReset(2);
    applyStimulus(6'h00, 6'h22, 0, 0, 0, trapped);

    applyStimulus(6'h23, 6'h20, 0, 0, 5, trapped);
    applyReset(1);

    applyStimulus(6'h00, 6'h18, 7, 2, 0, trapped);
    applyStimulus(6'h00, 6'h10, 0, 0, 0, trapped);

    sel = 1'b1;
    applyReset(1);
    applyStimulus(6'h00, 6'h1A, 5, 0, 0, trapped);
    applyStimulus(6'h00, 6'h18, 1, 0, 0, trapped);

    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      applyReset(1);
      for (int n = 0; n < 40; n++) begin
        c = cls_t'($urandom_range(0, 8));
        pickEncoding(c, op, fn);
        applyStimulus(op, fn, int'($urandom_range(1, sel ? 7 : 10)), 0, 2, trapped);
        if (trapped) applyReset(1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
